// File: rtl/mul_iter_32b_pkg.sv
// mul_iter_32b_pkg: shared widths, step count and FSM encoding for the iterative multiplier
package mul_iter_32b_pkg;
  localparam int NBITS = 32;
  localparam int MUL_STEPS = 32;
  localparam int CNT_W = 6;
  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_CALC = 2'd1,
    STATE_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/mul_iter_32b_if.sv
// mul_iter_32b_if: val/rdy operand and result streams between execute stage and multiplier
interface mul_iter_32b_if;
  import mul_iter_32b_pkg::*;
  logic               istream_val;
  logic               istream_rdy;
  logic [2*NBITS-1:0] istream_msg;
  logic               ostream_val;
  logic               ostream_rdy;
  logic [NBITS-1:0]   ostream_msg;
  modport master (
    output istream_val, istream_msg, ostream_rdy,
    input  istream_rdy, ostream_val, ostream_msg
  );
  modport slave (
    input  istream_val, istream_msg, ostream_rdy,
    output istream_rdy, ostream_val, ostream_msg
  );
endinterface

// File: rtl/adder_32b.sv
// adder_32b: gate-level ripple-carry adder, carry-out dropped so the sum wraps mod 2^32
module adder_32b (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] sum_o
);
  logic [31:0] c;
  assign c[0] = 1'b0;
  for (genvar i = 0; i < 32; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    if (i < 31) begin : g_c
      assign c[i+1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end
endmodule

// File: rtl/mul_iter_32b_dpath.sv
// mul_iter_32b_dpath: shift-and-add registers, one adder pass into the accumulator per step
module mul_iter_32b_dpath
  import mul_iter_32b_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             add_i,
  input  logic [NBITS-1:0] a_i,
  input  logic [NBITS-1:0] b_i,
  output logic             b_lsb_o,
  output logic [NBITS-1:0] acc_o
);
  logic [NBITS-1:0] a_q, b_q, acc_q, sum;
  adder_32b u_add (.a_i(acc_q), .b_i(a_q), .sum_o(sum));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (load_i) begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= '0;
    end else if (step_i) begin
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      acc_q <= add_i ? sum : acc_q;
    end
  end
  assign b_lsb_o = b_q[0];
  assign acc_o   = acc_q;
endmodule

// File: rtl/mul_iter_32b.sv
// mul_iter_32b: iterative 32x32 multiplier returning the low product word over val/rdy streams
module mul_iter_32b
  import mul_iter_32b_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  mul_iter_32b_if.slave s
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load, step, b_lsb;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STATE_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    load          = 1'b0;
    step          = 1'b0;
    s.istream_rdy = 1'b0;
    s.ostream_val = 1'b0;
    case (state_q)
      STATE_IDLE: begin
        s.istream_rdy = 1'b1;
        if (s.istream_val) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = STATE_CALC;
        end
      end
      STATE_CALC: begin
        step  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MUL_STEPS - 1)) state_d = STATE_DONE;
      end
      STATE_DONE: begin
        s.ostream_val = 1'b1;
        if (s.ostream_rdy) state_d = STATE_IDLE;
      end
      default: state_d = STATE_IDLE;
    endcase
  end
  mul_iter_32b_dpath u_dpath (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .step_i (step),
    .add_i  (step & b_lsb),
    .a_i    (s.istream_msg[2*NBITS-1:NBITS]),
    .b_i    (s.istream_msg[NBITS-1:0]),
    .b_lsb_o(b_lsb),
    .acc_o  (s.ostream_msg)
  );
endmodule

// File: tb/tb_mul_iter_32b.sv
// tb_mul_iter_32b: directed and randomized checks of mul_iter_32b against a plain a*b model
module tb_mul_iter_32b;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  mul_iter_32b_if bus ();
  mul_iter_32b dut (.clk(clk), .rst_n(rst_n), .s(bus.slave));
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    return p[31:0];
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    bus.istream_msg = {a, b};
    bus.istream_val = 1'b1;
    for (int n = 0; n < 100 && !bus.istream_rdy; n++) @(negedge clk);
    if (!bus.istream_rdy) begin
      errors++;
      $display("FAIL send_timeout: istream_rdy=%0b required 1", bus.istream_rdy);
    end
    @(posedge clk);
    @(negedge clk);
    bus.istream_val = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.ostream_val && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    bus.istream_val = 1'b0;
    bus.istream_msg = '0;
    bus.ostream_rdy = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.istream_rdy, bus.ostream_val, bus.ostream_msg} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_outputs: rdy/val/msg=%b/%b/%h required 1/0/00000000",
               bus.istream_rdy, bus.ostream_val, bus.ostream_msg);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    bus.ostream_rdy = 1'b1;
    send(32'd3, 32'd4);
    wait_out(lat);
    checks++;
    if (lat !== 32) begin
      errors++;
      $display("FAIL basic_latency: got %0d required 32", lat);
    end
    checks++;
    if (bus.ostream_msg !== 32'd12) begin
      errors++;
      $display("FAIL basic_msg: got %h required %h", bus.ostream_msg, 32'd12);
    end
    @(negedge clk);
    checks++;
    if ({bus.istream_rdy, bus.ostream_val} !== 2'b10) begin
      errors++;
      $display("FAIL basic_rdy_after_hs: rdy/val=%b/%b required 1/0", bus.istream_rdy, bus.ostream_val);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] ta [4] = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFB, 32'h0};
    logic [31:0] tb [4] = '{32'hFFFFFFFF, 32'h2, 32'h7, 32'h12345678};
    logic [31:0] te [4] = '{32'h1, 32'h0, 32'hFFFFFFDD, 32'h0};
    int lat;
    bus.ostream_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(ta[i], tb[i]);
      wait_out(lat);
      checks++;
      if (lat !== 32 || bus.ostream_msg !== te[i]) begin
        errors++;
        $display("FAIL wrap_%0d: got %h lat %0d required %h lat 32", i, bus.ostream_msg, lat, te[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] held;
    bus.ostream_rdy = 1'b0;
    send(32'h10000, 32'h10000);
    wait_out(lat);
    held = bus.ostream_msg;
    checks++;
    if (lat !== 32 || held !== 32'h0) begin
      errors++;
      $display("FAIL bp_first: got %h lat %0d required 00000000 lat 32", held, lat);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.ostream_val, bus.istream_rdy} !== 2'b10 || bus.ostream_msg !== held) begin
        errors++;
        $display("FAIL bp_hold_%0d: val/rdy=%b/%b msg %h required 1/0 msg %h",
                 i, bus.ostream_val, bus.istream_rdy, bus.ostream_msg, held);
      end
    end
    bus.ostream_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.istream_rdy, bus.ostream_val} !== 2'b10) begin
      errors++;
      $display("FAIL bp_release: rdy/val=%b/%b required 1/0", bus.istream_rdy, bus.ostream_val);
    end
  endtask

  task automatic test_busy();
    int lat;
    int extra = 0;
    bus.ostream_rdy = 1'b0;
    send(32'd1234, 32'd5678);
    bus.istream_val = 1'b1;
    bus.istream_msg = {32'd99, 32'd77};
    wait_out(lat);
    repeat (3) @(negedge clk);
    checks++;
    if (lat !== 32 || bus.ostream_msg !== ref_mul(32'd1234, 32'd5678)) begin
      errors++;
      $display("FAIL busy_result: got %h lat %0d required %h lat 32",
               bus.ostream_msg, lat, ref_mul(32'd1234, 32'd5678));
    end
    bus.ostream_rdy = 1'b1;
    @(negedge clk);
    bus.istream_val = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.ostream_val || !bus.istream_rdy) extra++;
      @(negedge clk);
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL busy_extra: got %0d busy cycles required 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bus.ostream_rdy = 1'b1;
    send(32'hDEADBEEF, 32'h13579BDF);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.istream_rdy, bus.ostream_val, bus.ostream_msg} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL midreset_outputs: rdy/val/msg=%b/%b/%h required 1/0/00000000",
               bus.istream_rdy, bus.ostream_val, bus.ostream_msg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(32'd6, 32'd7);
    wait_out(lat);
    checks++;
    if (lat !== 32 || bus.ostream_msg !== 32'd42) begin
      errors++;
      $display("FAIL midreset_newop: got %h lat %0d required 0000002a lat 32", bus.ostream_msg, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    logic [31:0] ra, rb;
    int sent = 0;
    int got = 0;
    bit pend = 1'b0;
    bus.istream_val = 1'b0;
    for (int cyc = 0; cyc < 40000 && got < 500; cyc++) begin
      @(negedge clk);
      if (!pend) bus.istream_val = 1'b0;
      if (!pend && sent < 500 && $urandom_range(3) != 0) begin
        ra = $urandom;
        rb = ($urandom_range(7) == 0) ? 32'hFFFFFFFF : $urandom;
        bus.istream_msg = {ra, rb};
        bus.istream_val = 1'b1;
        pend = 1'b1;
      end
      bus.ostream_rdy = ($urandom_range(3) != 0);
      if (bus.istream_val && bus.istream_rdy) begin
        q.push_back(ref_mul(ra, rb));
        sent++;
        pend = 1'b0;
      end
      if (bus.ostream_val && bus.ostream_rdy) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_unexpected: got %h with no operation pending", bus.ostream_msg);
        end else begin
          if (bus.ostream_msg !== q[0]) begin
            errors++;
            $display("FAIL rand_result_%0d: got %h required %h", got, bus.ostream_msg, q[0]);
          end
          void'(q.pop_front());
        end
        got++;
      end
    end
    @(negedge clk);
    bus.istream_val = 1'b0;
    checks++;
    if (got !== 500 || q.size() !== 0) begin
      errors++;
      $display("FAIL rand_count: got %0d results %0d pending required 500 and 0", got, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_busy();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
